// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder/subtractor.
package serial_adder_pkg;

    // Default operand/result width in bits (legal range 2..64).
    localparam int DEFAULT_WIDTH = 8;

    // Controller states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage : serial_adder_pkg

// File: rtl/serial_adder_full_adder.sv
// One-bit full adder built from two half adders and an OR gate.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic hs1;
    logic hc1;
    logic hc2;

    // First half adder: a + b.
    assign hs1 = a ^ b;
    assign hc1 = a & b;

    // Second half adder: partial sum + carry-in.
    assign s   = hs1 ^ cin;
    assign hc2 = hs1 & cin;

    // Either half adder may generate the carry.
    assign cout = hc1 | hc2;

endmodule : full_adder

// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: processes one operand bit per clock, LSB
// first, and publishes sum/carry/overflow together when the MSB completes.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             count,
    output logic             ovf
);

    localparam int              IW   = $clog2(WIDTH);
    localparam logic [IW-1:0]   LAST = IW'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] acc;
    logic [IW-1:0]    idx;
    logic             carry;
    logic             bit_s;
    logic             bit_c;

    full_adder u_fa (
        .a    (a_reg[idx]),
        .b    (b_reg[idx]),
        .cin  (carry),
        .s    (bit_s),
        .cout (bit_c)
    );

    // Controller, datapath registers and registered outputs.
    // Subtraction is in1 + ~in2 + 1: the latched sub bit seeds the carry,
    // so it needs no separate register afterwards. Partial sum bits build
    // up in acc and only reach sum on the final edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            count <= 1'b0;
            ovf   <= 1'b0;
            carry <= 1'b0;
            idx   <= '0;
            a_reg <= '0;
            b_reg <= '0;
            acc   <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_reg <= in1;
                        b_reg <= sub ? ~in2 : in2;
                        carry <= sub;
                        idx   <= '0;
                        acc   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    acc[idx] <= bit_s;
                    carry    <= bit_c;
                    if (idx == LAST) begin
                        sum   <= {bit_s, acc[WIDTH-2:0]};
                        count <= bit_c;
                        ovf   <= carry ^ bit_c;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule : serial_adder

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder at WIDTH=8.
module tb_serial_adder;

    logic       clk;
    logic       rst;
    logic       start;
    logic       sub;
    logic [7:0] in1;
    logic [7:0] in2;
    logic       busy;
    logic       done;
    logic [7:0] sum;
    logic       count;
    logic       ovf;

    int errors = 0;
    int checks = 0;

    serial_adder #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .sub   (sub),
        .in1   (in1),
        .in2   (in2),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .count (count),
        .ovf   (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present operands with a one-cycle start pulse.
    task automatic launch(input logic [7:0] a, input logic [7:0] b, input logic s);
        in1   = a;
        in2   = b;
        sub   = s;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Edges until done is seen, bounded at 20.
    task automatic wait_done(output int n);
        n = 0;
        while (!done && n < 20) begin
            tick();
            n++;
        end
    endtask

    // Launch, wait for completion and compare the result.
    task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input logic s, input logic [7:0] es, input logic ec,
                          input logic eo);
        int n;
        launch(a, b, s);
        check({tag, ".busy"}, busy, 1'b1);
        wait_done(n);
        check({tag, ".lat"}, n, 8);
        check({tag, ".sum"}, sum, es);
        check({tag, ".count"}, count, ec);
        check({tag, ".ovf"}, ovf, eo);
        tick();
        check({tag, ".done_clr"}, done, 1'b0);
        check({tag, ".idle"}, busy, 1'b0);
        check({tag, ".hold"}, sum, es);
    endtask

    initial begin
        int n;
        rst   = 1'b1;
        start = 1'b0;
        sub   = 1'b0;
        in1   = '0;
        in2   = '0;
        tick();
        tick();
        check("rst.busy", busy, 1'b0);
        check("rst.done", done, 1'b0);
        check("rst.sum", sum, 8'h00);
        check("rst.count", count, 1'b0);
        check("rst.ovf", ovf, 1'b0);

        // Start on the first edge after release; reset mid-RUN aborts.
        rst = 1'b0;
        launch(8'h12, 8'h34, 1'b0);
        tick(); tick(); tick();
        check("abort.busy_pre", busy, 1'b1);
        rst = 1'b1;
        #1;
        check("abort.busy", busy, 1'b0);
        check("abort.done", done, 1'b0);
        check("abort.sum", sum, 8'h00);
        tick();
        check("abort.done2", done, 1'b0);
        rst = 1'b0;
        run_op("after_abort", 8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0);

        run_op("ff_plus_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
        run_op("7f_plus_01", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
        run_op("05_minus_07", 8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0);
        run_op("80_minus_01", 8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1);
        run_op("00_minus_00", 8'h00, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0);
        run_op("a5_plus_5a", 8'hA5, 8'h5A, 1'b0, 8'hFF, 1'b0, 1'b0);

        // start held with new operands during RUN is ignored.
        launch(8'h11, 8'h22, 1'b0);
        for (int i = 0; i < 6; i++) begin
            start = 1'b1;
            in1   = 8'hAA;
            in2   = 8'h55;
            sub   = 1'b1;
            tick();
        end
        start = 1'b0;
        check("hold.busy", busy, 1'b1);
        check("hold.sum_mid", sum, 8'hFF);
        n = 6;
        while (!done && n < 20) begin
            tick();
            n++;
        end
        check("hold.lat", n, 8);
        check("hold.sum", sum, 8'h33);
        tick();
        check("hold.single_done", done, 1'b0);

        // Back-to-back: start accepted in the DONE cycle.
        launch(8'h01, 8'h02, 1'b0);
        wait_done(n);
        check("b2b.lat1", n, 8);
        check("b2b.sum1", sum, 8'h03);
        in1   = 8'h10;
        in2   = 8'h20;
        sub   = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("b2b.busy_nogap", busy, 1'b1);
        check("b2b.done_once", done, 1'b0);
        check("b2b.sum_held", sum, 8'h03);
        wait_done(n);
        check("b2b.lat2", n, 8);
        check("b2b.sum2", sum, 8'h30);
        check("b2b.count2", count, 1'b0);
        tick();
        check("b2b.done_clr", done, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_serial_adder
